// File: rtl/block_swap_sched.sv
// Slot-table scheduler in front of block_swap_ctrl: resolves SD-block lookups to SRAM slots,
// picks a victim on a miss and sequences one swap, updating the table on completion.
module block_swap_sched #(
  parameter int NumSlots  = 4,
  parameter int AddrWidth = 21,
  parameter int IdxWidth  = $clog2(NumSlots)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lookup_valid_i,
  input  logic [AddrWidth-1:0] lookup_addr_i,
  input  logic                 lookup_we_i,
  output logic                 lookup_ready_o,
  output logic [IdxWidth-1:0]  lookup_idx_o,
  output logic                 busy_o,
  output logic                 swap_req_o,
  output logic [IdxWidth-1:0]  old_addr_idx_o,
  output logic [AddrWidth-1:0] old_addr_o,
  output logic [AddrWidth-1:0] new_addr_o,
  output logic                 block_only_load_on_o,
  input  logic                 swap_done_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, SWAP_WAIT, UPDATE} state_e;

  state_e state_q, state_d;

  logic [NumSlots-1:0]  valid_q, dirty_q;
  logic [AddrWidth-1:0] tag_q [NumSlots];
  logic [IdxWidth-1:0]  rr_q;

  logic [IdxWidth-1:0]  victim_q;
  logic [AddrWidth-1:0] old_addr_q, new_addr_q;
  logic                 only_load_q;

  logic                 hit, has_free;
  logic [IdxWidth-1:0]  hit_idx, free_idx, victim_idx;
  logic                 victim_valid, victim_dirty;
  logic [AddrWidth-1:0] victim_tag;
  logic                 accept_hit, take_miss;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_addr_i)) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    victim_idx   = has_free ? free_idx : rr_q;
    victim_valid = 1'b0;
    victim_dirty = 1'b0;
    victim_tag   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (victim_idx == IdxWidth'(i)) begin
        victim_valid = valid_q[i];
        victim_dirty = dirty_q[i];
        victim_tag   = tag_q[i];
      end
    end
  end

  assign accept_hit = (state_q == IDLE) && lookup_valid_i && hit;
  assign take_miss  = (state_q == IDLE) && lookup_valid_i && !hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (take_miss) state_d = ISSUE;
      ISSUE:     state_d = SWAP_WAIT;
      SWAP_WAIT: if (swap_done_i) state_d = UPDATE;
      UPDATE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    lookup_ready_o       = accept_hit;
    lookup_idx_o         = accept_hit ? hit_idx : '0;
    busy_o               = (state_q != IDLE);
    swap_req_o           = (state_q == ISSUE);
    old_addr_idx_o       = victim_q;
    old_addr_o           = old_addr_q;
    new_addr_o           = new_addr_q;
    block_only_load_on_o = only_load_q;
  end

  // Swap parameters are captured at miss time so they stay stable through UPDATE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_q    <= '0;
      old_addr_q  <= '0;
      new_addr_q  <= '0;
      only_load_q <= 1'b0;
      rr_q        <= '0;
    end else if (take_miss) begin
      victim_q    <= victim_idx;
      old_addr_q  <= victim_valid ? victim_tag : '0;
      new_addr_q  <= lookup_addr_i;
      only_load_q <= !(victim_valid && victim_dirty);
      if (!has_free) begin
        rr_q <= (rr_q == IdxWidth'(NumSlots - 1)) ? '0 : rr_q + IdxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NumSlots; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (accept_hit && lookup_we_i && (hit_idx == IdxWidth'(i))) dirty_q[i] <= 1'b1;
        if ((state_q == UPDATE) && (victim_q == IdxWidth'(i))) begin
          valid_q[i] <= 1'b1;
          dirty_q[i] <= 1'b0;
          tag_q[i]   <= new_addr_q;
        end
      end
    end
  end

  // A pending lookup must keep its request, address and direction until accepted.
  lookup_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lookup_valid_i && !lookup_ready_o) |=>
      (lookup_valid_i && $stable(lookup_addr_i) && $stable(lookup_we_i)));

endmodule

// File: tb/tb_block_swap_sched.sv
// Directed bench for block_swap_sched: a 4-slot and a 3-slot instance share clock, reset,
// address and swap_done; each has its own lookup_valid so they are exercised one at a time.
module tb_block_swap_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid4, valid3, we, swap_done;
  logic [20:0] addr;

  logic        ready4, busy4, req4, only4;
  logic [1:0]  idx4, oidx4;
  logic [20:0] oaddr4, naddr4;
  logic        ready3, busy3, req3, only3;
  logic [1:0]  idx3, oidx3;
  logic [20:0] oaddr3, naddr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  block_swap_sched #(.NumSlots(4), .AddrWidth(21)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_valid_i(valid4), .lookup_addr_i(addr), .lookup_we_i(we),
    .lookup_ready_o(ready4), .lookup_idx_o(idx4), .busy_o(busy4),
    .swap_req_o(req4), .old_addr_idx_o(oidx4), .old_addr_o(oaddr4),
    .new_addr_o(naddr4), .block_only_load_on_o(only4), .swap_done_i(swap_done)
  );

  block_swap_sched #(.NumSlots(3), .AddrWidth(21)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_valid_i(valid3), .lookup_addr_i(addr), .lookup_we_i(we),
    .lookup_ready_o(ready3), .lookup_idx_o(idx3), .busy_o(busy3),
    .swap_req_o(req3), .old_addr_idx_o(oidx3), .old_addr_o(oaddr3),
    .new_addr_o(naddr3), .block_only_load_on_o(only3), .swap_done_i(swap_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v4, input logic v3, input logic [20:0] a, input logic w);
    valid4 = v4;
    valid3 = v3;
    addr   = a;
    we     = w;
  endtask

  // Full miss: request, issue, wait, done pulse, update, then the pending lookup hits.
  task automatic missSwap(input logic use3, input logic [20:0] a, input logic w,
                          input logic [1:0] e_idx, input logic [20:0] e_old, input logic e_only);
    @(negedge clk);
    applyStimulus(!use3, use3, a, w);
    #1;
    checkOutput("miss_ready", use3 ? ready3 : ready4, 0);
    checkOutput("miss_req", use3 ? req3 : req4, 0);
    @(negedge clk);
    checkOutput("issue_req", use3 ? req3 : req4, 1);
    checkOutput("issue_busy", use3 ? busy3 : busy4, 1);
    checkOutput("issue_old_idx", use3 ? oidx3 : oidx4, e_idx);
    checkOutput("issue_old_addr", use3 ? oaddr3 : oaddr4, e_old);
    checkOutput("issue_new_addr", use3 ? naddr3 : naddr4, a);
    checkOutput("issue_only_load", use3 ? only3 : only4, e_only);
    @(negedge clk);
    checkOutput("wait_req", use3 ? req3 : req4, 0);
    checkOutput("wait_ready", use3 ? ready3 : ready4, 0);
    swap_done = 1'b1;
    @(negedge clk);
    swap_done = 1'b0;
    checkOutput("update_ready", use3 ? ready3 : ready4, 0);
    checkOutput("update_old_idx", use3 ? oidx3 : oidx4, e_idx);
    @(negedge clk);
    checkOutput("after_busy", use3 ? busy3 : busy4, 0);
    checkOutput("after_ready", use3 ? ready3 : ready4, 1);
    checkOutput("after_idx", use3 ? idx3 : idx4, e_idx);
    @(negedge clk);
    applyStimulus(0, 0, a, 0);
  endtask

  task automatic hitLookup(input logic use3, input logic [20:0] a, input logic w, input logic [1:0] e_idx);
    @(negedge clk);
    applyStimulus(!use3, use3, a, w);
    #1;
    checkOutput("hit_ready", use3 ? ready3 : ready4, 1);
    checkOutput("hit_idx", use3 ? idx3 : idx4, e_idx);
    checkOutput("hit_req", use3 ? req3 : req4, 0);
    @(negedge clk);
    applyStimulus(0, 0, a, 0);
    checkOutput("hit_busy", use3 ? busy3 : busy4, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    swap_done = 1'b0;
    applyStimulus(0, 0, 21'h0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", ready4, 0);
    checkOutput("rst_busy", busy4, 0);
    checkOutput("rst_req", req4, 0);
    checkOutput("rst_old_idx", oidx4, 0);
    checkOutput("rst_old_addr", oaddr4, 0);
    checkOutput("rst_new_addr", naddr4, 0);
    checkOutput("rst_only_load", only4, 0);
    checkOutput("rst_idx", idx4, 0);
    rst_n = 1'b1;

    // Fill the 4-slot table with free-slot victims, then hit and dirty.
    missSwap(0, 21'h100, 0, 2'd0, 21'h0, 1);
    missSwap(0, 21'h101, 0, 2'd1, 21'h0, 1);
    missSwap(0, 21'h102, 0, 2'd2, 21'h0, 1);
    missSwap(0, 21'h103, 0, 2'd3, 21'h0, 1);
    hitLookup(0, 21'h102, 0, 2'd2);
    hitLookup(0, 21'h100, 1, 2'd0);

    // Full table: round-robin victims, dirty write-back, pointer wrap.
    missSwap(0, 21'h200, 0, 2'd0, 21'h100, 0);
    missSwap(0, 21'h300, 0, 2'd1, 21'h101, 1);
    missSwap(0, 21'h301, 0, 2'd2, 21'h102, 1);
    missSwap(0, 21'h302, 0, 2'd3, 21'h103, 1);
    missSwap(0, 21'h303, 0, 2'd0, 21'h200, 1);
    missSwap(0, 21'h304, 0, 2'd1, 21'h300, 1);
    missSwap(0, 21'h400, 1, 2'd2, 21'h301, 1);
    missSwap(0, 21'h401, 0, 2'd3, 21'h302, 1);
    missSwap(0, 21'h402, 0, 2'd0, 21'h303, 1);
    missSwap(0, 21'h403, 0, 2'd1, 21'h304, 1);
    missSwap(0, 21'h404, 0, 2'd2, 21'h400, 0);

    // Spurious done in IDLE does nothing.
    @(negedge clk);
    swap_done = 1'b1;
    @(negedge clk);
    swap_done = 1'b0;
    checkOutput("spurious_busy", busy4, 0);
    checkOutput("spurious_req", req4, 0);
    hitLookup(0, 21'h404, 0, 2'd2);

    // Reset while waiting for a swap.
    @(negedge clk);
    applyStimulus(1, 0, 21'h500, 0);
    @(negedge clk);
    checkOutput("mid_issue_old_idx", oidx4, 3);
    checkOutput("mid_issue_old_addr", oaddr4, 21'h401);
    @(negedge clk);
    checkOutput("mid_wait_busy", busy4, 1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 21'h500, 0);
    #1;
    checkOutput("midrst_busy", busy4, 0);
    checkOutput("midrst_req", req4, 0);
    checkOutput("midrst_old_idx", oidx4, 0);
    checkOutput("midrst_old_addr", oaddr4, 0);
    checkOutput("midrst_new_addr", naddr4, 0);
    checkOutput("midrst_only_load", only4, 0);
    checkOutput("midrst_ready", ready4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    swap_done = 1'b1;
    @(negedge clk);
    swap_done = 1'b0;
    checkOutput("late_done_busy", busy4, 0);
    checkOutput("late_done_req", req4, 0);
    missSwap(0, 21'h100, 0, 2'd0, 21'h0, 1);

    // Three-slot instance: pointer wraps 2 -> 0.
    missSwap(1, 21'h10, 0, 2'd0, 21'h0, 1);
    missSwap(1, 21'h11, 0, 2'd1, 21'h0, 1);
    missSwap(1, 21'h12, 0, 2'd2, 21'h0, 1);
    missSwap(1, 21'h20, 0, 2'd0, 21'h10, 1);
    missSwap(1, 21'h21, 0, 2'd1, 21'h11, 1);
    missSwap(1, 21'h22, 0, 2'd2, 21'h12, 1);
    missSwap(1, 21'h23, 0, 2'd0, 21'h20, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_swap_sched.md
Name: block_swap_sched

Overview:
Scheduler that sits in front of block_swap_ctrl in the user domain. It owns the slot table that maps SD-card block addresses to SRAM block slots, and resolves lookups as hit or miss. On a miss it selects a victim slot, sequences a single swap through block_swap_ctrl, and updates the table when the swap completes. It decides when a swap is a load-only swap and when it must first write the old block back.

Parameters:
NumSlots, NUM_SRAM_ADDRESSES (user_pkg), number of SRAM block slots; any value >= 2, need not be a power of two
AddrWidth, 21, SD-card block address width
IdxWidth, $clog2(NumSlots), slot index width (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
lookup_valid_i  in  1  lookup request; held with stable addr/we until lookup_ready_o
lookup_addr_i  in  AddrWidth  SD-card block address to resolve
lookup_we_i  in  1  access is a write; marks the slot dirty on hit
lookup_ready_o  out  1  lookup accepted this cycle (always a hit)
lookup_idx_o  out  IdxWidth  slot holding lookup_addr_i; valid when lookup_ready_o
busy_o  out  1  swap in progress (state != IDLE)
swap_req_o  out  1  one-cycle start pulse to block_swap_ctrl
old_addr_idx_o  out  IdxWidth  victim slot index
old_addr_o  out  AddrWidth  tag currently held by the victim (write-back target)
new_addr_o  out  AddrWidth  block to load (the missing lookup_addr_i)
block_only_load_on_o  out  1  1 = skip write-back
swap_done_i  in  1  one-cycle completion pulse from block_swap_ctrl

Behaviour:
- Table: NumSlots entries, each {valid, dirty, tag[AddrWidth-1:0]}. Reset: all valid=0, dirty=0, tag=0. Round-robin pointer rr_q resets to 0.
- States: IDLE, ISSUE, SWAP_WAIT, UPDATE. Reset state is IDLE.
- Output reset values: all outputs are 0.
- IDLE, lookup_valid_i=1:
  - Compare lookup_addr_i combinationally against every valid tag.
  - Hit: lookup_ready_o=1 and lookup_idx_o=matching slot in the same cycle (0-cycle latency). If lookup_we_i=1, set that entry's dirty bit at the clock edge.
  - Miss: lookup_ready_o=0. Latch victim and new address, then go to ISSUE.
  - A tag matches at most one valid slot by construction. The compare is a priority encoder, lowest index first.
- Victim selection:
  - The lowest-index invalid slot if any exists; otherwise rr_q.
  - rr_q advances only when the victim was taken from it. It wraps from NumSlots-1 to 0.
- block_only_load_on_o = !(victim.valid && victim.dirty). old_addr_o = victim.tag (0 when the victim is invalid).
- Swap handshake:
  - ISSUE: swap_req_o=1 for exactly one cycle, then go to SWAP_WAIT.
  - old_addr_idx_o, old_addr_o, new_addr_o and block_only_load_on_o come from registers. They are stable from ISSUE until UPDATE inclusive.
- SWAP_WAIT:
  - Wait for swap_done_i; no timeout.
  - swap_done_i in any other state is ignored.
  - lookup_valid_i is not serviced while busy; lookup_ready_o=0.
- UPDATE (one cycle):
  - Write the victim entry: tag=new addr, valid=1, dirty=0.
  - Return to IDLE.
  - The still-pending lookup hits on the next cycle. It then sets dirty if lookup_we_i=1.
- Miss latency: lookup_valid_i first sampled in IDLE at cycle N gives swap_req_o at N+1. swap_done_i at cycle M gives UPDATE at M+1 and lookup_ready_o at M+2.
- Lookup_addr_i change while unacknowledged is a protocol violation; behaviour is undefined (assert in simulation).
- Reset mid-swap: the table clears and the state goes to IDLE. Any later swap_done_i is ignored.

Test Plan:
- NumSlots=4, after reset: lookup 0x100 (read) -> swap_req_o at N+1, old_addr_idx_o=0, block_only_load_on_o=1, new_addr_o=0x100. Then swap_done_i -> lookup_ready_o=1 and lookup_idx_o=0 two cycles later.
- Fill slots with 0x100..0x103, then lookup 0x102 -> lookup_ready_o=1 in the same cycle, lookup_idx_o=2, swap_req_o never asserted.
- Write-hit 0x100 (we=1), then miss 0x200 with all slots valid and rr_q=0 -> old_addr_idx_o=0, old_addr_o=0x100, block_only_load_on_o=0. After update: slot0 tag=0x200, dirty=0, rr_q=1.
- Five consecutive clean misses on a full table -> victims 1,2,3,0,1 (pointer wrap). block_only_load_on_o=1 each time.
- NumSlots=3: four misses on a full table -> rr_q wraps 2 to 0 and never produces index 3.
- Spurious swap_done_i in IDLE is ignored. rst_ni low during SWAP_WAIT -> all outputs 0, state IDLE, next lookup 0x100 misses to slot 0.
